// File: rtl/pad_loader.sv
// Zero-padded frame loader: fills the interior of an (N+2)x(N+2) pixel
// matrix in raster order and hands each complete frame to the consumer.
module pad_loader #(
    parameter int PW = 8,
    parameter int N  = 9
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [PW-1:0]             pix_in,
    input  logic                      pix_valid,
    input  logic                      pix_sof,
    output logic                      pix_ready,
    output logic [(N+2)*(N+2)*PW-1:0] matrix,
    output logic                      values,
    output logic                      frame_valid,
    input  logic                      mat_ack,
    output logic                      sof_err
);

    localparam int S  = N + 2;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int NN = N * N;
    localparam int AW = (NN > 1) ? $clog2(NN) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic {
        LOAD,
        HOLD
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  r_q, r_d;
    logic [CW-1:0]  c_q, c_d;
    logic           values_q, values_d;
    logic           fv_q, fv_d;
    logic           err_q, err_d;
    logic [PW-1:0]  mem_q [NN];

    logic           accept;
    logic           at_origin;
    logic           last;
    logic [CW-1:0]  wr_r;
    logic [CW-1:0]  wr_c;
    logic [AW-1:0]  wr_idx;

    // A start-of-frame pixel always lands at the first interior slot.
    always_comb begin
        accept    = pix_valid && (state_q == LOAD);
        at_origin = (r_q == '0) && (c_q == '0);
        wr_r      = pix_sof ? '0 : r_q;
        wr_c      = pix_sof ? '0 : c_q;
        last      = (wr_r == LAST) && (wr_c == LAST);
        wr_idx    = AW'(wr_r) * AW'(N) + AW'(wr_c);
    end

    always_comb begin
        state_d  = state_q;
        r_d      = r_q;
        c_d      = c_q;
        values_d = 1'b0;
        fv_d     = fv_q;
        err_d    = err_q;
        unique case (state_q)
            LOAD: begin
                if (accept) begin
                    if (pix_sof != at_origin) begin
                        err_d = 1'b1;
                    end
                    if (last) begin
                        state_d  = HOLD;
                        r_d      = '0;
                        c_d      = '0;
                        values_d = 1'b1;
                        fv_d     = 1'b1;
                    end else if (wr_c == LAST) begin
                        r_d = wr_r + 1'b1;
                        c_d = '0;
                    end else begin
                        r_d = wr_r;
                        c_d = wr_c + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (mat_ack) begin
                    state_d = LOAD;
                    fv_d    = 1'b0;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= LOAD;
            r_q      <= '0;
            c_q      <= '0;
            values_q <= 1'b0;
            fv_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            r_q      <= r_d;
            c_q      <= c_d;
            values_q <= values_d;
            fv_q     <= fv_d;
            err_q    <= err_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NN; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NN; i++) begin
                if (accept && (wr_idx == AW'(i))) begin
                    mem_q[i] <= pix_in;
                end
            end
        end
    end

    // Border elements are constant zero; only the interior is stored.
    for (genvar rr = 0; rr < S; rr++) begin : g_row
        for (genvar cc = 0; cc < S; cc++) begin : g_col
            if (rr == 0 || rr == S - 1 || cc == 0 || cc == S - 1) begin : g_bd
                assign matrix[(rr*S+cc)*PW +: PW] = '0;
            end else begin : g_in
                assign matrix[(rr*S+cc)*PW +: PW] = mem_q[(rr-1)*N+(cc-1)];
            end
        end
    end

    assign pix_ready   = (state_q == LOAD);
    assign values      = values_q;
    assign frame_valid = fv_q;
    assign sof_err     = err_q;

endmodule

// File: tb/tb_pad_loader.sv
// Scenario bench for pad_loader: a pixel-level model pushes expected
// frames to a scoreboard that is drained on every load strobe.
module tb_pad_loader;

    localparam int PW = 8;
    localparam int N  = 9;
    localparam int S  = N + 2;
    localparam int MW = S * S * PW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [PW-1:0] pix_in = '0;
    logic          pix_valid = 1'b0;
    logic          pix_sof = 1'b0;
    logic          pix_ready;
    logic [MW-1:0] matrix;
    logic          values;
    logic          frame_valid;
    logic          mat_ack = 1'b0;
    logic          sof_err;

    int total = 0;
    int bad = 0;
    int n_strobe = 0;
    int n_hold = 0;

    int            exp_r = 0;
    int            exp_c = 0;
    logic [PW-1:0] exp_mem [N*N];
    logic [MW-1:0] sb [$];
    logic [MW-1:0] saved;

    pad_loader #(.PW(PW), .N(N)) dut (
        .clk(clk),
        .rst(rst),
        .pix_in(pix_in),
        .pix_valid(pix_valid),
        .pix_sof(pix_sof),
        .pix_ready(pix_ready),
        .matrix(matrix),
        .values(values),
        .frame_valid(frame_valid),
        .mat_ack(mat_ack),
        .sof_err(sof_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    function automatic logic [PW-1:0] el(input logic [MW-1:0] m,
                                         input int r, input int c);
        return m[(r*S+c)*PW +: PW];
    endfunction

    function automatic logic [MW-1:0] build_exp();
        logic [MW-1:0] m;
        m = '0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                m[((r+1)*S+c+1)*PW +: PW] = exp_mem[r*N+c];
        return m;
    endfunction

    task automatic model_reset();
        exp_r = 0;
        exp_c = 0;
        for (int i = 0; i < N*N; i++) exp_mem[i] = '0;
        sb.delete();
    endtask

    task automatic model_accept(input logic [PW-1:0] v, input bit sof);
        int r;
        int c;
        r = sof ? 0 : exp_r;
        c = sof ? 0 : exp_c;
        exp_mem[r*N+c] = v;
        if (r == N-1 && c == N-1) begin
            sb.push_back(build_exp());
            exp_r = 0;
            exp_c = 0;
        end else if (c == N-1) begin
            exp_r = r + 1;
            exp_c = 0;
        end else begin
            exp_r = r;
            exp_c = c + 1;
        end
    endtask

    task automatic send(input logic [PW-1:0] v, input bit sof);
        int guard;
        guard = 0;
        pix_in = v;
        pix_sof = sof;
        pix_valid = 1'b1;
        while (!pix_ready && guard < 20) begin
            @(posedge clk);
            #1;
            guard++;
        end
        total++;
        if (guard >= 20) begin
            bad++;
            $display("FAIL send_timeout pix_ready=%b want=1", pix_ready);
        end else begin
            model_accept(v, sof);
            @(posedge clk);
            #1;
        end
        pix_valid = 1'b0;
        pix_sof = 1'b0;
    endtask

    task automatic ack();
        mat_ack = 1'b1;
        @(posedge clk);
        #1;
        mat_ack = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst && !pix_ready) n_hold++;
        if (rst && values) begin
            n_strobe++;
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL strobe_unexpected values=1 want=0");
            end else begin
                logic [MW-1:0] e;
                e = sb.pop_front();
                if (matrix !== e) begin
                    bad++;
                    for (int i = 0; i < S*S; i++)
                        if (matrix[i*PW +: PW] !== e[i*PW +: PW]) begin
                            $display("FAIL sb_matrix elem=%0d got=%h want=%h",
                                     i, matrix[i*PW +: PW], e[i*PW +: PW]);
                            break;
                        end
                end
            end
            total++;
            if (frame_valid !== 1'b1) begin
                bad++;
                $display("FAIL strobe_fv got=%b want=1", frame_valid);
            end
        end
    end

    task automatic test_reset();
        model_reset();
        rst = 1'b0;
        #12;
        total++;
        if ({pix_ready, values, frame_valid, sof_err} !== 4'b1000) begin
            bad++;
            $display("FAIL reset_outs got=%b want=1000",
                     {pix_ready, values, frame_valid, sof_err});
        end
        total++;
        if (matrix !== '0) begin
            bad++;
            $display("FAIL reset_matrix got=nonzero want=0");
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_frame();
        int s0;
        int nb;
        s0 = n_strobe;
        for (int k = 1; k <= N*N; k++) send(PW'(k), k == 1);
        total++;
        if (values !== 1'b1) begin
            bad++;
            $display("FAIL frame_strobe got=%b want=1", values);
        end
        total++;
        if (el(matrix, 1, 1) !== 8'd1 || el(matrix, 9, 9) !== 8'd81 ||
            el(matrix, 5, 5) !== 8'd41) begin
            bad++;
            $display("FAIL frame_elems got=%0d,%0d,%0d want=1,81,41",
                     el(matrix, 1, 1), el(matrix, 9, 9), el(matrix, 5, 5));
        end
        nb = 0;
        for (int r = 0; r < S; r++)
            for (int c = 0; c < S; c++)
                if ((r == 0 || r == S-1 || c == 0 || c == S-1) &&
                    el(matrix, r, c) !== '0) nb++;
        total++;
        if (nb != 0) begin
            bad++;
            $display("FAIL frame_border nonzero=%0d want=0", nb);
        end
        total++;
        if (frame_valid !== 1'b1 || pix_ready !== 1'b0) begin
            bad++;
            $display("FAIL frame_hold fv=%b rdy=%b want=1,0",
                     frame_valid, pix_ready);
        end
        @(posedge clk);
        #1;
        total++;
        if (values !== 1'b0 || n_strobe - s0 != 1) begin
            bad++;
            $display("FAIL frame_pulse values=%b strobes=%0d want=0,1",
                     values, n_strobe - s0);
        end
        saved = matrix;
    endtask

    task automatic test_hold();
        int s0;
        s0 = n_strobe;
        pix_in = 8'hFF;
        pix_valid = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        pix_valid = 1'b0;
        total++;
        if (matrix !== saved || n_strobe != s0 || frame_valid !== 1'b1) begin
            bad++;
            $display("FAIL hold_stable strobes=%0d fv=%b want=0,1",
                     n_strobe - s0, frame_valid);
        end
        ack();
        total++;
        if (pix_ready !== 1'b1 || frame_valid !== 1'b0) begin
            bad++;
            $display("FAIL hold_ack rdy=%b fv=%b want=1,0",
                     pix_ready, frame_valid);
        end
    endtask

    task automatic test_gaps();
        int s0;
        s0 = n_strobe;
        for (int k = 1; k <= N*N; k++) begin
            if ($urandom_range(1, 0) == 1) begin
                @(posedge clk);
                #1;
            end
            send(PW'(k), k == 1);
        end
        @(posedge clk);
        #1;
        total++;
        if (matrix !== saved || n_strobe - s0 != 1) begin
            bad++;
            $display("FAIL gaps strobes=%0d want=1 same=%b",
                     n_strobe - s0, matrix === saved);
        end
        ack();
    endtask

    task automatic test_resync();
        int s0;
        for (int k = 1; k < 40; k++) send(PW'(k + 100), k == 1);
        s0 = n_strobe;
        for (int k = 1; k < N*N; k++) send(PW'(k * 3), k == 1);
        total++;
        if (sof_err !== 1'b1 || frame_valid !== 1'b0 || n_strobe != s0) begin
            bad++;
            $display("FAIL resync_pre err=%b fv=%b strobes=%0d want=1,0,0",
                     sof_err, frame_valid, n_strobe - s0);
        end
        send(PW'(N * N * 3), 1'b0);
        @(posedge clk);
        #1;
        total++;
        if (n_strobe - s0 != 1 || el(matrix, 1, 1) !== 8'd3) begin
            bad++;
            $display("FAIL resync_post strobes=%0d m11=%0d want=1,3",
                     n_strobe - s0, el(matrix, 1, 1));
        end
        ack();
    endtask

    task automatic test_reset_mid();
        for (int k = 1; k <= 30; k++) send(PW'(k + 7), k == 1);
        rst = 1'b0;
        #1;
        total++;
        if (matrix !== '0 || pix_ready !== 1'b1 || sof_err !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_clear rdy=%b err=%b want=1,0",
                     pix_ready, sof_err);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 1; k <= N*N; k++) send(PW'(255 - k), k == 1);
        @(posedge clk);
        #1;
        total++;
        if (sof_err !== 1'b0 || frame_valid !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_frame err=%b fv=%b want=0,1",
                     sof_err, frame_valid);
        end
        ack();
    endtask

    task automatic test_back_to_back();
        int s0;
        int h0;
        s0 = n_strobe;
        h0 = n_hold;
        mat_ack = 1'b1;
        for (int k = 1; k <= N*N; k++) send(PW'(k * 5), k == 1);
        for (int k = 1; k <= N*N; k++) send(PW'(k + 60), k == 1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        mat_ack = 1'b0;
        total++;
        if (n_strobe - s0 != 2 || n_hold - h0 != 2) begin
            bad++;
            $display("FAIL b2b strobes=%0d hold=%0d want=2,2",
                     n_strobe - s0, n_hold - h0);
        end
        total++;
        if (sb.size() != 0 || pix_ready !== 1'b1) begin
            bad++;
            $display("FAIL b2b_end pending=%0d rdy=%b want=0,1",
                     sb.size(), pix_ready);
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_hold();
        test_gaps();
        test_resync();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pad_loader.md
PAD_LOADER -- requirements
Module: pad_loader

Interface
REQ-001 SHALL have parameter PW, default 8: pixel width in bits.
REQ-002 SHALL have parameter N, default 9: unpadded image side; padded side is N+2.
REQ-003 SHALL have port clk, input, 1 bit: single clock, all state on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port pix_in, input, PW bits: unsigned pixel data.
REQ-006 SHALL have port pix_valid, input, 1 bit: pix_in valid this cycle.
REQ-007 SHALL have port pix_sof, input, 1 bit: qualifies the pixel as start-of-frame, meaningful only with pix_valid.
REQ-008 SHALL have port pix_ready, output, 1 bit: block accepts a pixel this cycle.
REQ-009 SHALL have port matrix, output, (N+2)*(N+2)*PW bits (968 at defaults): padded image, element (r,c) at bits [(r*(N+2)+c)*PW +: PW].
REQ-010 SHALL have port values, output, 1 bit: one-cycle load strobe to the convolution stage.
REQ-011 SHALL have port frame_valid, output, 1 bit: matrix holds a complete frame.
REQ-012 SHALL have port mat_ack, input, 1 bit: consumer releases the frame.
REQ-013 SHALL have port sof_err, output, 1 bit: sticky framing error.

Function
REQ-014 SHALL accept a pixel on a rising edge only when pix_valid=1 and pix_ready=1.
REQ-015 SHALL implement two states, LOAD and HOLD, with pix_ready=1 exactly in LOAD.
REQ-016 SHALL keep row counter r and column counter c, each 0..N-1, with raster order c fastest.
REQ-017 SHALL write an accepted pixel to matrix element (r+1,c+1).
REQ-018 SHALL hold border elements (row 0, row N+1, column 0, column N+1) at zero at all times.
REQ-019 SHALL, on an accepted pixel with pix_sof=1, store it at (1,1) and set r=0, c=1, whatever the prior count.
REQ-020 SHALL set sof_err on an accepted pix_sof when (r,c) is not (0,0), and also on an accepted pixel at (0,0) without pix_sof.
REQ-021 SHALL keep sof_err set until reset; frame loading continues unaffected.
REQ-022 SHALL, on acceptance of the pixel at (N-1,N-1), go to HOLD, reset r and c to 0, set frame_valid=1, and pulse values=1 for exactly the next cycle; latency from last-pixel edge to strobe visible is 0 cycles (registered outputs update on that edge).
REQ-023 SHALL keep matrix stable throughout HOLD.
REQ-024 SHALL ignore pix_valid during HOLD; no pixel is lost because pix_ready=0.
REQ-025 SHALL, on mat_ack=1 in HOLD, return to LOAD, clear frame_valid, and raise pix_ready from the next cycle.
REQ-026 SHALL ignore mat_ack in LOAD, including in the same cycle as the last pixel.
REQ-027 SHALL leave interior elements of the previous frame in place until overwritten by the new frame; it does not clear them.
REQ-028 SHALL keep frame_valid=0 for a frame restarted mid-load by pix_sof until (N-1,N-1) is reached.

Reset
REQ-029 SHALL, on rst=0, immediately force: matrix all zero, r=c=0, state LOAD, pix_ready=1, values=0, frame_valid=0, sof_err=0.
REQ-030 SHALL discard a partial frame on reset asserted mid-load; after release, loading starts at (0,0).
REQ-031 SHALL start operation on the first rising edge after rst deasserts.

Verification
REQ-032 SHALL pass this test: feed 81 pixels, value k for the k-th pixel (1..81), first with sof, no gaps -> values pulses once on the cycle after pixel 81; matrix(1,1)=1, matrix(9,9)=81, matrix(5,5)=41; all 40 border bytes=0; frame_valid=1; pix_ready=0.
REQ-033 SHALL pass this test: in HOLD, drive pix_valid=1 with pix_in=0xFF for 10 cycles -> matrix unchanged and no strobe; assert mat_ack -> pix_ready=1 next cycle and frame_valid=0.
REQ-034 SHALL pass this test: random pix_valid gaps (50% duty) over a full frame -> same matrix contents as the no-gap run and exactly one values pulse.
REQ-035 SHALL pass this test: sof at pixel 40, then 81 more pixels -> sof_err=1; the strobe follows only the 81st pixel after the resync; matrix(1,1) holds the resync pixel.
REQ-036 SHALL pass this test: rst=0 after pixel 30, release, then a full frame -> matrix reflects only the new frame and sof_err=0.
REQ-037 SHALL pass this test: mat_ack held at 1 during LOAD -> no effect; with mat_ack held continuously, back-to-back frames each produce one strobe and a one-cycle HOLD.
